// File: rtl/tick_wd_pkg.sv
// Shared types and helpers for the tick watchdog: FSM state encoding,
// miss counter width and the interval tolerance test.
package tick_wd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } wd_state_t;

  localparam int MISS_W = 2;

  // Written as interval+tol >= period so a short interval cannot underflow.
  function automatic logic in_tol(input int unsigned interval,
                                  input int unsigned period,
                                  input int unsigned tol);
    return ((interval + tol) >= period) && (interval <= (period + tol));
  endfunction

endpackage

// File: rtl/tick_interval_ctr.sv
// Interval counter: counts cycles while running, reloads to zero on request,
// and flags when the count sits on the timeout boundary.
module tick_interval_ctr
  import tick_wd_pkg::*;
#(
  parameter int CBITS = 16,
  parameter int LIMIT = 17503
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             reload_i,
  output logic [CBITS-1:0] cnt_o,
  output logic             timeout_o
);

  localparam logic [CBITS-1:0] LIMIT_C = CBITS'(LIMIT);

  logic [CBITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (reload_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o     = cnt_q;
  assign timeout_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/tick_watchdog.sv
// Tick watchdog: measures the spacing of upstream ticks, locks after a run of
// in-tolerance intervals, and reports early/late ticks and a sticky fault.
module tick_watchdog
  import tick_wd_pkg::*;
#(
  parameter int PERIOD     = 17501,
  parameter int TOL        = 2,
  parameter int CBITS      = 16,
  parameter int LOCK_GOOD  = 4,
  parameter int MISS_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              tick_err,
  input  logic              clr,
  output logic              locked,
  output logic              early,
  output logic              late,
  output logic              fault,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [CBITS-1:0]  period_meas,
  output logic [1:0]        state_o
);

  localparam int GBITS = $clog2(LOCK_GOOD + 1);
  localparam logic [GBITS-1:0]  GOOD_MAX  = GBITS'(LOCK_GOOD);
  localparam logic [MISS_W-1:0] MISS_MAX  = '1;
  localparam logic [CBITS:0]    EARLY_LIM = (CBITS+1)'(PERIOD - TOL);

  wd_state_t         state_q;
  logic [GBITS-1:0]  good_q;
  logic [MISS_W-1:0] miss_q;
  logic              early_q;
  logic              late_q;
  logic [CBITS-1:0]  period_q;

  logic [CBITS-1:0]  cnt;
  logic              at_limit;
  logic              active;
  logic              ctr_reload;
  logic [CBITS:0]    interval;
  logic              is_good;
  logic              is_early;
  logic              timeout_hit;
  logic [GBITS-1:0]  good_inc;
  logic [MISS_W-1:0] miss_inc;

  assign active      = (state_q == TRACK) || (state_q == LOCKED);
  assign interval    = {1'b0, cnt} + (CBITS+1)'(1);
  assign is_good     = in_tol(32'(interval), PERIOD, TOL);
  assign is_early    = (interval < EARLY_LIM);
  assign timeout_hit = active && at_limit && !tick && !tick_err && !clr;
  assign good_inc    = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
  assign miss_inc    = (miss_q == MISS_MAX) ? miss_q : miss_q + 1'b1;

  // A tick on the boundary cycle reloads as a tick, so it suppresses the timeout.
  assign ctr_reload = clr || (state_q == IDLE) ||
                      (active && !tick_err && (tick || at_limit));

  tick_interval_ctr #(
    .CBITS (CBITS),
    .LIMIT (PERIOD + TOL)
  ) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (active),
    .reload_i  (ctr_reload),
    .cnt_o     (cnt),
    .timeout_o (at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      good_q   <= '0;
      miss_q   <= '0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      period_q <= '0;
    end else begin
      early_q <= 1'b0;
      late_q  <= 1'b0;
      if (clr) begin
        state_q <= IDLE;
        good_q  <= '0;
        miss_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (tick) state_q <= TRACK;
          end
          TRACK, LOCKED: begin
            if (tick_err) begin
              state_q <= FAULT;
            end else if (tick) begin
              period_q <= interval[CBITS-1:0];
              if (is_good) begin
                miss_q <= '0;
                good_q <= good_inc;
                if (state_q == TRACK && good_inc == GOOD_MAX) state_q <= LOCKED;
              end else if (is_early) begin
                early_q <= 1'b1;
                good_q  <= '0;
                if (state_q == LOCKED) state_q <= FAULT;
              end else begin
                good_q <= '0;
              end
            end else if (timeout_hit) begin
              late_q <= 1'b1;
              good_q <= '0;
              miss_q <= miss_inc;
              if (32'(miss_inc) >= MISS_LIMIT) state_q <= FAULT;
              else if (state_q == LOCKED)      state_q <= TRACK;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign locked      = (state_q == LOCKED);
  assign fault       = (state_q == FAULT);
  assign early       = early_q;
  assign late        = late_q;
  assign miss_cnt    = miss_q;
  assign period_meas = period_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_tick_watchdog.sv
// Directed bench for tick_watchdog with a short period so lock, early, late
// and fault paths are reached within a few hundred cycles.
module tb_tick_watchdog;

  localparam int PERIOD     = 20;
  localparam int TOL        = 2;
  localparam int CBITS      = 16;
  localparam int LOCK_GOOD  = 4;
  localparam int MISS_LIMIT = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             tick     = 1'b0;
  logic             tick_err = 1'b0;
  logic             clr      = 1'b0;
  logic             locked;
  logic             early;
  logic             late;
  logic             fault;
  logic [1:0]       miss_cnt;
  logic [CBITS-1:0] period_meas;
  logic [1:0]       state_o;

  int tests_run  = 0;
  int fails      = 0;
  int early_seen = 0;
  int late_seen  = 0;

  always #5 clk = ~clk;

  tick_watchdog #(
    .PERIOD     (PERIOD),
    .TOL        (TOL),
    .CBITS      (CBITS),
    .LOCK_GOOD  (LOCK_GOOD),
    .MISS_LIMIT (MISS_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .tick_err    (tick_err),
    .clr         (clr),
    .locked      (locked),
    .early       (early),
    .late        (late),
    .fault       (fault),
    .miss_cnt    (miss_cnt),
    .period_meas (period_meas),
    .state_o     (state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    if (early) early_seen++;
    if (late)  late_seen++;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Next tick is sampled k rising edges after the previous one.
  task automatic tick_after(input int k);
    wait_cycles(k - 1);
    pulse_tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic do_lock();
    pulse_tick();
    for (int i = 0; i < LOCK_GOOD; i++) tick_after(PERIOD);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    tests_run++; if ({locked, early, late, fault} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {locked, early, late, fault}); end
    tests_run++; if (miss_cnt !== 2'd0) begin fails++; $display("FAIL reset_miss: got %0d expected 0", miss_cnt); end
    tests_run++; if (period_meas !== 16'd0) begin fails++; $display("FAIL reset_period: got %0d expected 0", period_meas); end
    tests_run++; if (state_o !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", state_o, S_IDLE); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lock();
    early_seen = 0; late_seen = 0;
    pulse_tick();
    tests_run++; if (state_o !== S_TRACK) begin fails++; $display("FAIL lock_first_tick_state: got %0d expected %0d", state_o, S_TRACK); end
    for (int i = 0; i < LOCK_GOOD; i++) begin
      tick_after(PERIOD);
      tests_run++; if (locked !== (i == LOCK_GOOD - 1)) begin fails++; $display("FAIL lock_progress_%0d: got %b expected %b", i, locked, (i == LOCK_GOOD - 1)); end
    end
    tests_run++; if (period_meas !== 16'd20) begin fails++; $display("FAIL lock_period: got %0d expected 20", period_meas); end
    tests_run++; if (early_seen !== 0 || late_seen !== 0) begin fails++; $display("FAIL lock_no_pulses: got early=%0d late=%0d expected 0 0", early_seen, late_seen); end
    tests_run++; if (fault !== 1'b0) begin fails++; $display("FAIL lock_no_fault: got %b expected 0", fault); end
  endtask

  task automatic test_early_fault();
    early_seen = 0;
    tick_after(17);
    tests_run++; if (early !== 1'b1) begin fails++; $display("FAIL early_pulse: got %b expected 1", early); end
    tests_run++; if ({fault, locked} !== 2'b10) begin fails++; $display("FAIL early_fault_locked: got %b expected 10", {fault, locked}); end
    tests_run++; if (period_meas !== 16'd17) begin fails++; $display("FAIL early_period: got %0d expected 17", period_meas); end
    step();
    tests_run++; if (early !== 1'b0 || early_seen !== 1) begin fails++; $display("FAIL early_width: got early=%b seen=%0d expected 0 1", early, early_seen); end
    tick_after(PERIOD);
    tests_run++; if (state_o !== S_FAULT || early_seen !== 1) begin fails++; $display("FAIL fault_sticky: got state=%0d seen=%0d expected 3 1", state_o, early_seen); end
    do_clr();
    tests_run++; if (fault !== 1'b0 || state_o !== S_IDLE) begin fails++; $display("FAIL clr_to_idle: got fault=%b state=%0d expected 0 0", fault, state_o); end
    tests_run++; if (period_meas !== 16'd17) begin fails++; $display("FAIL clr_period_held: got %0d expected 17", period_meas); end
  endtask

  task automatic test_timeouts();
    do_lock();
    late_seen = 0;
    wait_cycles(22);
    tests_run++; if (late_seen !== 0) begin fails++; $display("FAIL late_not_before_23: got %0d expected 0", late_seen); end
    step();
    tests_run++; if (late !== 1'b1 || miss_cnt !== 2'd1) begin fails++; $display("FAIL late_1: got late=%b miss=%0d expected 1 1", late, miss_cnt); end
    tests_run++; if (state_o !== S_TRACK) begin fails++; $display("FAIL late_1_state: got %0d expected %0d", state_o, S_TRACK); end
    wait_cycles(22);
    step();
    tests_run++; if (late !== 1'b1 || miss_cnt !== 2'd2 || fault !== 1'b0) begin fails++; $display("FAIL late_2: got late=%b miss=%0d fault=%b expected 1 2 0", late, miss_cnt, fault); end
    wait_cycles(22);
    step();
    tests_run++; if (late !== 1'b1 || miss_cnt !== 2'd3 || fault !== 1'b1) begin fails++; $display("FAIL late_3: got late=%b miss=%0d fault=%b expected 1 3 1", late, miss_cnt, fault); end
    step();
    tests_run++; if (late !== 1'b0) begin fails++; $display("FAIL late_width: got %b expected 0", late); end
    wait_cycles(40);
    tests_run++; if (late_seen !== 3 || fault !== 1'b1 || miss_cnt !== 2'd3) begin fails++; $display("FAIL fault_frozen: got late_seen=%0d fault=%b miss=%0d expected 3 1 3", late_seen, fault, miss_cnt); end
    do_clr();
    tests_run++; if (miss_cnt !== 2'd0 || fault !== 1'b0) begin fails++; $display("FAIL clr_miss: got miss=%0d fault=%b expected 0 0", miss_cnt, fault); end
  endtask

  task automatic test_tolerance_edges();
    do_lock();
    early_seen = 0; late_seen = 0;
    tick_after(22);
    tests_run++; if (period_meas !== 16'd22 || locked !== 1'b1) begin fails++; $display("FAIL tol_22: got period=%0d locked=%b expected 22 1", period_meas, locked); end
    tick_after(18);
    tests_run++; if (period_meas !== 16'd18 || locked !== 1'b1) begin fails++; $display("FAIL tol_18: got period=%0d locked=%b expected 18 1", period_meas, locked); end
    tick_after(PERIOD);
    tests_run++; if (early_seen !== 0 || late_seen !== 0 || locked !== 1'b1) begin fails++; $display("FAIL tol_no_pulses: got early=%0d late=%0d locked=%b expected 0 0 1", early_seen, late_seen, locked); end
    tick_after(23);
    wait_cycles(2);
    tests_run++; if (late_seen !== 0 || period_meas !== 16'd23) begin fails++; $display("FAIL tick_wins_boundary: got late=%0d period=%0d expected 0 23", late_seen, period_meas); end
    do_clr();
  endtask

  task automatic test_tick_err();
    tick_err = 1'b1;
    step();
    tick_err = 1'b0;
    tests_run++; if (fault !== 1'b0 || state_o !== S_IDLE) begin fails++; $display("FAIL err_idle_ignored: got fault=%b state=%0d expected 0 0", fault, state_o); end
    pulse_tick();
    tick_after(10);
    tests_run++; if (early !== 1'b1 || state_o !== S_TRACK) begin fails++; $display("FAIL track_early: got early=%b state=%0d expected 1 1", early, state_o); end
    tick_err = 1'b1;
    step();
    tick_err = 1'b0;
    tests_run++; if (fault !== 1'b1 || state_o !== S_FAULT) begin fails++; $display("FAIL err_track_fault: got fault=%b state=%0d expected 1 3", fault, state_o); end
    do_clr();
  endtask

  task automatic test_async_reset();
    do_lock();
    tests_run++; if (locked !== 1'b1) begin fails++; $display("FAIL areset_prelock: got %b expected 1", locked); end
    wait_cycles(7);
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({locked, early, late, fault, miss_cnt, state_o} !== 8'b0 || period_meas !== 16'd0) begin fails++; $display("FAIL areset_immediate: got flags=%b period=%0d expected 0 0", {locked, early, late, fault, miss_cnt, state_o}, period_meas); end
    step();
    rst_n = 1'b1;
    step();
    tests_run++; if (state_o !== S_IDLE) begin fails++; $display("FAIL areset_idle: got %0d expected 0", state_o); end
    pulse_tick();
    tick_after(PERIOD);
    tests_run++; if (period_meas !== 16'd20 || state_o !== S_TRACK) begin fails++; $display("FAIL areset_restart: got period=%0d state=%0d expected 20 1", period_meas, state_o); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_early_fault();
    test_timeouts();
    test_tolerance_edges();
    test_tick_err();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
